// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing helpers for the HI/LO multiplier.
//   state_t      : controller states (IDLE, CALC, FIX)
//   ITER, CNT_W  : iteration count and counter width for the default build
//   iter_count() / cnt_width() : the same sizing for any WIDTH/BITS_PER_CYCLE
package mult_pkg;

  localparam int unsigned MULT_WIDTH          = 32;
  localparam int unsigned MULT_BITS_PER_CYCLE = 1;

  function automatic int unsigned iter_count(input int unsigned width,
                                             input int unsigned bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Never narrower than one bit, so a single-iteration build still has a counter.
  function automatic int unsigned cnt_width(input int unsigned iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  localparam int unsigned ITER  = iter_count(MULT_WIDTH, MULT_BITS_PER_CYCLE);
  localparam int unsigned CNT_W = cnt_width(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step.sv
// mult_step: one shift-add iteration of the multiplier (purely combinational).
//   acc      in  [2*WIDTH-1:0]      running partial-product sum
//   mcand    in  [WIDTH-1:0]        unsigned multiplicand magnitude
//   chunk    in  [BITS_PER_CYCLE-1:0] multiplier bits retired this cycle
//   shift    in  [SHIFT_W-1:0]      bit position of chunk within the multiplier
//   acc_next out [2*WIDTH-1:0]      acc + (mcand * chunk) << shift
module mult_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned SHIFT_W        = 6
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [SHIFT_W-1:0]        shift,
  output logic [2*WIDTH-1:0]        acc_next
);

  logic [2*WIDTH-1:0] partial;

  always_comb begin
    partial  = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, chunk};
    acc_next = acc + (partial << shift);
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative shift-add MULT/MULTU unit owning the HI/LO registers.
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start_mult in   start request (accepted only in IDLE without mult_flush)
//   mult_sign  in   1 = signed (MULT), 0 = unsigned (MULTU), sampled with start
//   mult_flush in   abort in-flight operation; also blocks a start in IDLE
//   src_a      in   multiplicand (rs), sampled with start
//   src_b      in   multiplier (rt), sampled with start
//   busy       out  high whenever the unit is not IDLE (decoded from state)
//   done       out  one-cycle pulse after HI/LO are written
//   hi, lo     out  upper / lower halves of the committed product
// Optional build macro MULT_EARLY_TERM_EN: leave CALC as soon as the remaining
// multiplier bits are zero. Results are identical either way; only latency changes.
module mult_hilo_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH          = MULT_WIDTH,
  parameter int unsigned BITS_PER_CYCLE = MULT_BITS_PER_CYCLE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic             mult_flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N_ITER  = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned N_CNT_W = cnt_width(N_ITER);
  localparam int unsigned SHIFT_W = $clog2(2*WIDTH);

  state_t               state, state_next;
  logic [N_CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 neg, neg_in;
  logic [2*WIDTH-1:0]   acc, acc_next, product;
  logic [SHIFT_W-1:0]   shift_pos;
  logic                 start_ok;
  logic                 calc_last;

  // Signed mode works on magnitudes; 0x80..0 negates to itself, which is
  // exactly its unsigned magnitude.
  always_comb begin
    a_mag    = (mult_sign && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag    = (mult_sign && src_b[WIDTH-1]) ? -src_b : src_b;
    neg_in   = mult_sign && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
    start_ok = start_mult && !mult_flush;
  end

  // The multiplier register is shifted each cycle, so its low bits are always
  // the current chunk; the accumulator position is recovered from the counter.
  always_comb begin
    shift_pos = (SHIFT_W'(N_ITER - 1) - SHIFT_W'(cnt)) * SHIFT_W'(BITS_PER_CYCLE);
  end

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHIFT_W        (SHIFT_W)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .chunk    (mplier[BITS_PER_CYCLE-1:0]),
    .shift    (shift_pos),
    .acc_next (acc_next)
  );

  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    calc_last = (cnt == '0) || ((mplier >> BITS_PER_CYCLE) == '0);
`else
    calc_last = (cnt == '0);
`endif
  end

  always_comb begin
    product = neg ? -acc : acc;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = CALC;
      CALC: begin
        if (mult_flush)     state_next = IDLE;
        else if (calc_last) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= neg_in;
            acc    <= '0;
            cnt    <= N_CNT_W'(N_ITER - 1);
          end
        end
        CALC: begin
          if (!mult_flush) begin
            acc    <= acc_next;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!mult_flush) begin
            hi   <= product[2*WIDTH-1:WIDTH];
            lo   <= product[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
Iterative shift-add multiplier that consumes the start_mult/mult_sign controls issued for MULT/MULTU and holds the HI/LO result read back by MFHI/MFLO. It sits beside the ALU in the execute stage. It raises busy so the hazard unit stalls any MFHI, MFLO or new MULT until the product is committed. The block owns the HI and LO registers.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH
BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; must divide WIDTH (1, 2, 4 legal)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start_mult  input  1  start request from the control unit (execute stage)
mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start_mult
mult_flush  input  1  abort in-flight operation (pipeline flush)
src_a  input  WIDTH  multiplicand (rs), sampled with start_mult
src_b  input  WIDTH  multiplier (rt), sampled with start_mult
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after HI/LO are written
hi  output  WIDTH  HI register, product[2*WIDTH-1:WIDTH]
lo  output  WIDTH  LO register, product[WIDTH-1:0]

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, internal accumulator and counters cleared. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE: if start_mult=1 and mult_flush=0 at an edge, latch operands and sign mode, then go to CALC with counter = ITER-1, where ITER = WIDTH/BITS_PER_CYCLE.
- Signed mode: latch |src_a| and |src_b| as WIDTH-bit unsigned magnitudes (0x80000000 gives magnitude 0x80000000) and record neg = a[MSB]^b[MSB]. Unsigned mode: latch raw operands, neg = 0.
- CALC: each cycle add (multiplicand * low BITS_PER_CYCLE multiplier bits) into a 2*WIDTH accumulator at the current shift position. Shift the multiplier right by BITS_PER_CYCLE and decrement the counter. When counter = 0, go to FIX.
- FIX: product = neg ? two's-complement of accumulator (mod 2^(2*WIDTH)) : accumulator. Write {hi,lo} = product, then go to IDLE. done=1 for exactly the following cycle.
- Latency (defaults): start accepted at edge 0; CALC occupies edges 1..32; FIX commits at edge 33. busy is high during cycles 1..33 and done is high in cycle 34.
- hi/lo keep their previous values throughout CALC/FIX. They change only at the FIX commit or on reset.
- start_mult while busy=1 is ignored; the control unit must stall.
- mult_flush=1 in CALC or FIX: return to IDLE at that edge, leave hi/lo unchanged, no done pulse.
- mult_flush=1 together with start_mult=1 in IDLE: flush wins and nothing starts.
- done and start_mult in the same cycle: the new start is accepted normally (state is IDLE).
- All outputs are registered except busy, which decodes state.

Optional Feature:
MULT_EARLY_TERM_EN
- Defined: in CALC, if the remaining unshifted multiplier bits are all zero, go to FIX at that edge. Minimum latency is start edge + 1 CALC edge + FIX edge.
- Not defined: fixed ITER CALC cycles regardless of operand values.
- Results are bit-identical with and without the macro.

Decomposition:
- Package mult_pkg: state enum (IDLE, CALC, FIX), localparam ITER, and localparam CNT_W = clog2(ITER).
- One sub-module, mult_step: combinational single-iteration datapath taking accumulator, multiplicand, multiplier chunk and shift position, and producing the next accumulator. The FSM, counter, sign handling and HI/LO registers stay in mult_hilo_unit.

Test Plan:
1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done in cycle 34.
2. MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
3. Commit hi/lo=0x0/0x15, then start 0x10*0x10 and pulse start_mult again at cycle 5 -> second start ignored; final lo=0x100 at cycle 34; hi/lo read 0x0/0x15 during cycles 1..33.
4. Start 0x1234*0x5678, assert mult_flush at cycle 10 -> busy=0 from cycle 11, no done, hi/lo unchanged. Flush and start together in IDLE -> busy stays 0.
5. Drop reset_n at cycle 15 of an operation -> hi=lo=0 and busy=0 immediately. After release, start 2*3 -> lo=6.
6. With MULT_EARLY_TERM_EN defined: MULTU 5*3 -> lo=15, done within 4 cycles. Without the macro -> done at cycle 34, same value.
